spi_byte_queue: RTL and testbench

Buffered byte-stream front end for the SPI master: accepts bytes from the host over a valid/ready interface, launches one SPI master transfer per byte, and returns each received MISO byte through a second valid/ready interface. Sits directly upstream of the SPI master. It drives the master's `start`/`data_in` and consumes its `data_out`/`done`, so the host never has to track the master's IDLE/START/TRANS/DONE sequence.

---
 rtl/spi_byte_queue_if.sv | 20 ++
 rtl/spi_byte_queue.sv | 169 ++++++++++++++++
 tb/tb_spi_byte_queue.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_byte_queue_if.sv
// Host-side byte streams of spi_byte_queue: TX bytes in, received MISO bytes out.
// The host drives the master modport, the queue sits on the slave modport.
interface spi_byte_queue_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_byte_queue.sv
// Buffered byte front end for the SPI master: TX FIFO -> one master transfer per byte -> RX FIFO.
// Optional inter-frame gap state compiled in with SPI_BYTE_QUEUE_GAP_EN.
module spi_byte_queue #(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 4,
    localparam int LW        = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    spi_byte_queue_if.slave host,
    output logic          m_start,
    output logic [7:0]    m_data_in,
    input  logic [7:0]    m_data_out,
    input  logic          m_done,
    output logic [LW-1:0] tx_level,
    output logic [LW-1:0] rx_level,
    output logic          busy
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] ONE_LVL  = LW'(1);
    localparam logic [LW-1:0] ZERO_LVL = LW'(0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);

    if (DEPTH < 32'sd2 || (DEPTH & (DEPTH - 32'sd1)) != 32'sd0) begin : g_bad_depth
        $error("spi_byte_queue: DEPTH must be a power of two >= 2");
    end
    if (GAP_CYCLES < 32'sd1 || GAP_CYCLES > 32'sd255) begin : g_bad_gap
        $error("spi_byte_queue: GAP_CYCLES must be in 1..255");
    end

`ifdef SPI_BYTE_QUEUE_GAP_EN
    typedef enum logic [1:0] {Q_IDLE = 2'd0, Q_LAUNCH = 2'd1, Q_WAIT = 2'd2, Q_GAP = 2'd3} q_state_t;
    logic [7:0] gap_cnt_r;
`else
    typedef enum logic [1:0] {Q_IDLE = 2'd0, Q_LAUNCH = 2'd1, Q_WAIT = 2'd2} q_state_t;
`endif

    q_state_t      state_r, state_nxt_s;
    logic [7:0]    tx_mem_r [DEPTH];
    logic [7:0]    rx_mem_r [DEPTH];
    logic [PW-1:0] tx_wptr_r, tx_rptr_r, rx_wptr_r, rx_rptr_r;
    logic [LW-1:0] tx_level_r, rx_level_r, tx_level_nxt_s, rx_level_nxt_s;
    logic          tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
    logic          tx_ready_r, rx_valid_r, m_start_r, busy_r;
    logic [7:0]    m_data_in_r;

    // FIFO handshakes; every term comes from registers or qualifies a registered flag
    always_comb begin
        tx_push_s = host.tx_valid && tx_ready_r;
        tx_pop_s  = (state_r == Q_LAUNCH);
        rx_push_s = (state_r == Q_WAIT) && m_done;
        rx_pop_s  = rx_valid_r && host.rx_ready;
    end

    // Occupancy next values; simultaneous push and pop leave a level unchanged
    always_comb begin
        tx_level_nxt_s = tx_level_r;
        rx_level_nxt_s = rx_level_r;
        if (tx_push_s && !tx_pop_s) begin
            tx_level_nxt_s = tx_level_r + ONE_LVL;
        end else if (!tx_push_s && tx_pop_s) begin
            tx_level_nxt_s = tx_level_r - ONE_LVL;
        end else begin
            tx_level_nxt_s = tx_level_r;
        end
        if (rx_push_s && !rx_pop_s) begin
            rx_level_nxt_s = rx_level_r + ONE_LVL;
        end else if (!rx_push_s && rx_pop_s) begin
            rx_level_nxt_s = rx_level_r - ONE_LVL;
        end else begin
            rx_level_nxt_s = rx_level_r;
        end
    end

    // FIFO pointers, levels and the flags derived from the next levels
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wptr_r  <= PTR_ZERO;
            tx_rptr_r  <= PTR_ZERO;
            rx_wptr_r  <= PTR_ZERO;
            rx_rptr_r  <= PTR_ZERO;
            tx_level_r <= ZERO_LVL;
            rx_level_r <= ZERO_LVL;
            tx_ready_r <= 1'b1;
            rx_valid_r <= 1'b0;
        end else begin
            if (tx_push_s) tx_wptr_r <= tx_wptr_r + PTR_ONE;
            if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + PTR_ONE;
            if (rx_push_s) rx_wptr_r <= rx_wptr_r + PTR_ONE;
            if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + PTR_ONE;
            tx_level_r <= tx_level_nxt_s;
            rx_level_r <= rx_level_nxt_s;
            tx_ready_r <= (tx_level_nxt_s != FULL_LVL);
            rx_valid_r <= (rx_level_nxt_s != ZERO_LVL);
        end
    end

    // Storage arrays; contents are don't-care while the matching level says empty
    always_ff @(posedge clk) begin
        if (tx_push_s) tx_mem_r[tx_wptr_r] <= host.tx_data;
        if (rx_push_s) rx_mem_r[rx_wptr_r] <= m_data_out;
    end

    // Next state; RX space is reserved at launch because only one transfer is ever in flight
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            Q_IDLE: begin
                if (tx_level_r != ZERO_LVL && rx_level_r != FULL_LVL) state_nxt_s = Q_LAUNCH;
                else                                                  state_nxt_s = Q_IDLE;
            end
            Q_LAUNCH: state_nxt_s = Q_WAIT;
            Q_WAIT: begin
`ifdef SPI_BYTE_QUEUE_GAP_EN
                if (m_done) state_nxt_s = Q_GAP;
`else
                if (m_done) state_nxt_s = Q_IDLE;
`endif
                else        state_nxt_s = Q_WAIT;
            end
`ifdef SPI_BYTE_QUEUE_GAP_EN
            Q_GAP: begin
                if (gap_cnt_r == 8'd0) state_nxt_s = Q_IDLE;
                else                   state_nxt_s = Q_GAP;
            end
`endif
            default: state_nxt_s = Q_IDLE;
        endcase
    end

    // State register and registered master-side outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= Q_IDLE;
            m_start_r   <= 1'b0;
            m_data_in_r <= 8'h00;
            busy_r      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            m_start_r <= (state_nxt_s == Q_LAUNCH);
            busy_r    <= (state_nxt_s != Q_IDLE);
            if (state_nxt_s == Q_LAUNCH) m_data_in_r <= tx_mem_r[tx_rptr_r];
        end
    end

`ifdef SPI_BYTE_QUEUE_GAP_EN
    // Gap countdown: loaded on leaving Q_WAIT so Q_GAP lasts exactly GAP_CYCLES clocks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_cnt_r <= 8'd0;
        end else if (state_r == Q_WAIT && state_nxt_s == Q_GAP) begin
            gap_cnt_r <= 8'(GAP_CYCLES - 1);
        end else if (state_r == Q_GAP && gap_cnt_r != 8'd0) begin
            gap_cnt_r <= gap_cnt_r - 8'd1;
        end
    end
`endif

    assign host.tx_ready = tx_ready_r;
    assign host.rx_valid = rx_valid_r;
    assign host.rx_data  = rx_valid_r ? rx_mem_r[rx_rptr_r] : 8'h00;
    assign tx_level      = tx_level_r;
    assign rx_level      = rx_level_r;
    assign m_start       = m_start_r;
    assign m_data_in     = m_data_in_r;
    assign busy          = busy_r;
endmodule

// File: tb/tb_spi_byte_queue.sv
// Directed bench for spi_byte_queue with a loopback SPI master and a queue-level reference model.
module tb_spi_byte_queue;
    localparam int DEPTH   = 8;
    localparam int LW      = 4;
    localparam int MST_LAT = 3;
`ifdef SPI_BYTE_QUEUE_GAP_EN
    localparam int MGAP = 4;
`else
    localparam int MGAP = 0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m_start;
    logic [7:0]    m_data_in;
    logic [7:0]    m_data_out = 8'h00;
    logic          m_done = 1'b0;
    logic [LW-1:0] tx_level, rx_level;
    logic          busy;

    spi_byte_queue_if bus();

    spi_byte_queue #(.DEPTH(DEPTH), .GAP_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .host(bus),
        .m_start(m_start), .m_data_in(m_data_in),
        .m_data_out(m_data_out), .m_done(m_done),
        .tx_level(tx_level), .rx_level(rx_level), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: byte queues plus transfer bookkeeping in edge numbers
    logic [7:0] tq[$];
    logic [7:0] rq[$];
    int         cyc = 0;
    int         earliest = 0;
    int         launch_edge = -10;
    bit         in_flight = 1'b0;
    logic [7:0] exp_mdi = 8'h00;
    bit         chk_en = 1'b0;

    int         mst_cnt = 0;
    logic [7:0] mst_byte = 8'h00;
    bit         inj_done = 1'b0;
    int         start_cnt = 0;
    int         done_drv_cyc = -100;
    int         gap_meas = -1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic model_clear();
        tq.delete();
        rq.delete();
        in_flight   = 1'b0;
        earliest    = cyc;
        launch_edge = -10;
        exp_mdi     = 8'h00;
        mst_cnt     = 0;
        m_done      = 1'b0;
        inj_done    = 1'b0;
    endtask

    // One clock edge as seen by the queue rules, using pre-edge occupancy
    task automatic model_update();
        int tsz;
        int rsz;
        bit launch_now;
        cyc++;
        tsz = tq.size();
        rsz = rq.size();
        launch_now = !in_flight && (cyc >= earliest) && (tsz != 0) && (rsz != DEPTH);
        if (in_flight && launch_edge == cyc - 1) void'(tq.pop_front());
        if (bus.tx_valid && tsz != DEPTH) tq.push_back(bus.tx_data);
        if (bus.rx_ready && rsz != 0) void'(rq.pop_front());
        if (in_flight && cyc >= launch_edge + 2 && m_done) begin
            rq.push_back(m_data_out);
            in_flight = 1'b0;
            earliest  = cyc + 1 + MGAP;
        end
        if (launch_now) begin
            in_flight   = 1'b1;
            launch_edge = cyc;
            exp_mdi     = tq[0];
        end
    endtask

    // Advance one clock; afterwards play the loopback SPI master for the next cycle
    task automatic step();
        @(posedge clk);
        if (reset) model_update();
        #1;
        m_done   = inj_done;
        inj_done = 1'b0;
        if (!reset) begin
            mst_cnt = 0;
            m_done  = 1'b0;
        end else begin
            if (mst_cnt > 0) begin
                mst_cnt--;
                if (mst_cnt == 0) begin
                    m_done     = 1'b1;
                    m_data_out = mst_byte;
                end
            end
            if (m_start) begin
                mst_byte = m_data_in;
                mst_cnt  = MST_LAT;
                start_cnt++;
                gap_meas = cyc - done_drv_cyc;
            end
        end
        if (m_done) done_drv_cyc = cyc;
    endtask

    task automatic push(input logic [7:0] b);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        step();
        bus.tx_valid = 1'b0;
    endtask

    task automatic pop_rx();
        bus.rx_ready = 1'b1;
        step();
        bus.rx_ready = 1'b0;
    endtask

    task automatic run_until_quiet(input string name, input int max);
        int n = 0;
        while ((tq.size() != 0 || in_flight || cyc < earliest) && n < max) begin
            step();
            n++;
        end
        chk({name, "_quiet_in_time"}, int'(n < max), 1);
        step();
    endtask

    // Cycle-by-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_start", int'(m_start), int'(in_flight && launch_edge == cyc));
            chk("m_data_in", int'(m_data_in), int'(exp_mdi));
            chk("busy", int'(busy), int'(in_flight || (cyc < earliest - 1)));
            chk("tx_level", int'(tx_level), tq.size());
            chk("tx_ready", int'(bus.tx_ready), int'(tq.size() != DEPTH));
            chk("rx_level", int'(rx_level), rq.size());
            chk("rx_valid", int'(bus.rx_valid), int'(rq.size() != 0));
            chk("rx_data", int'(bus.rx_data), (rq.size() != 0) ? int'(rq[0]) : 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int n;
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;
        model_clear();
        #2 reset = 1'b0;
        #1;
        chk("rst_tx_level", int'(tx_level), 0);
        chk("rst_tx_ready", int'(bus.tx_ready), 1);
        chk("rst_rx_valid", int'(bus.rx_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_m_start", int'(m_start), 0);
        chk_en = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();

        // single byte through the loopback master
        push(8'hA5);
        run_until_quiet("single", 50);
        chk("single_starts", start_cnt, 1);
        chk("single_rx_data", int'(bus.rx_data), 8'hA5);
        chk("single_rx_level", int'(rx_level), 1);
        chk("single_busy", int'(busy), 0);
        pop_rx();

        // burst of DEPTH bytes without draining
        for (int i = 1; i <= 8; i++) push(8'(i));
        run_until_quiet("burst", 200);
        chk("burst_rx_level", int'(rx_level), 8);
        chk("burst_starts", start_cnt, 9);
        chk("burst_rx_head", int'(bus.rx_data), 8'h01);

        // RX full: nothing launches until one byte is taken
        s0 = start_cnt;
        push(8'h55);
        repeat (12) step();
        chk("stall_no_start", start_cnt, s0);
        chk("stall_tx_level", int'(tx_level), 1);
        pop_rx();
        run_until_quiet("stall", 50);
        chk("stall_one_start", start_cnt, s0 + 1);
        chk("stall_mdi", int'(m_data_in), 8'h55);
        chk("stall_rx_level", int'(rx_level), 8);
        chk("stall_rx_head", int'(bus.rx_data), 8'h02);

        // fill TX while RX is full, then one refused push
        for (int i = 0; i < 8; i++) push(8'(8'h60 + i));
        chk("full_tx_level", int'(tx_level), 8);
        chk("full_tx_ready", int'(bus.tx_ready), 0);
        push(8'h68);
        chk("refused_tx_level", int'(tx_level), 8);

        // drain RX while still pushing: concurrent push/pop on both FIFOs
        bus.rx_ready = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(8'h70 + i));
        run_until_quiet("drain", 600);
        step();
        chk("drain_rx_level", int'(rx_level), 0);
        bus.rx_ready = 1'b0;

        // back-to-back spacing: done cycle to next start
        push(8'h11);
        push(8'h22);
        run_until_quiet("gap", 100);
        chk("gap_done_to_start", gap_meas, 2 + MGAP);
        chk("gap_rx_level", int'(rx_level), 2);
        pop_rx();
        pop_rx();

        // reset while a transfer is in flight
        push(8'h31);
        push(8'h32);
        push(8'h33);
        n = 0;
        while (start_cnt == s0 + 1 + 24 && n < 40) begin step(); n++; end
        s0 = start_cnt;
        n = 0;
        while (!in_flight && n < 40) begin step(); n++; end
        chk("rst_wait_launch_in_time", int'(n < 40), 1);
        step();
        step();
        #2 reset = 1'b0;
        model_clear();
        #1;
        chk("mid_rst_tx_level", int'(tx_level), 0);
        chk("mid_rst_tx_ready", int'(bus.tx_ready), 1);
        chk("mid_rst_rx_valid", int'(bus.rx_valid), 0);
        chk("mid_rst_rx_data", int'(bus.rx_data), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_m_start", int'(m_start), 0);
        chk("mid_rst_m_data_in", int'(m_data_in), 0);
        step();
        step();
        reset = 1'b1;
        step();
        m_data_out = 8'hEE;
        inj_done   = 1'b1;
        step();
        step();
        step();
        chk("stray_done_rx_level", int'(rx_level), 0);
        chk("stray_done_busy", int'(busy), 0);

        // traffic after reset
        push(8'h3C);
        run_until_quiet("post_reset", 50);
        chk("post_rst_rx_data", int'(bus.rx_data), 8'h3C);
        chk("post_rst_rx_level", int'(rx_level), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
